// File: rtl/window_3x3_stream.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a shifting 3x3
// window register turn a raster pixel stream into every fully-populated window.
module window_3x3_stream #(
  parameter int DATA_W    = 8,
  parameter int IMG_W     = 258,
  parameter int IMG_H     = 34,
  parameter int ZERO_IDLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          win1,
  output logic [DATA_W-1:0]          win2,
  output logic [DATA_W-1:0]          win3,
  output logic [DATA_W-1:0]          win4,
  output logic [DATA_W-1:0]          win5,
  output logic [DATA_W-1:0]          win6,
  output logic [DATA_W-1:0]          win7,
  output logic [DATA_W-1:0]          win8,
  output logic [DATA_W-1:0]          win9,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       frame_done
);

  // Handshake: in_valid qualifies in_data/in_sof and every valid pixel is taken
  // (no ready). out_valid is a one-cycle strobe per window, also without ready.

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     col_q, cur_col, nxt_col;
  logic [RW-1:0]     row_q, cur_row, nxt_row;
  logic              at_last_col, at_last_row, emit;
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] lb1_rd, lb2_rd;
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];
  logic [DATA_W-1:0] tap_q [3][3];
  logic              tap_en;

  // A start-of-frame pixel is placed at (0,0) regardless of the counters.
  always_comb begin
    cur_col     = in_sof ? '0 : col_q;
    cur_row     = in_sof ? '0 : row_q;
    at_last_col = (cur_col == CW'(IMG_W - 1));
    at_last_row = (cur_row == RW'(IMG_H - 1));
    emit        = in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    nxt_col     = cur_col + CW'(1);
    nxt_row     = cur_row;
    if (at_last_col) begin
      nxt_col = '0;
      nxt_row = at_last_row ? '0 : cur_row + RW'(1);
    end
  end

  assign lb1_rd = lb1[cur_col];
  assign lb2_rd = lb2[cur_col];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_d[i][0] = win_q[i][1];
      win_d[i][1] = win_q[i][2];
    end
    win_d[0][2] = lb2_rd;
    win_d[1][2] = lb1_rd;
    win_d[2][2] = in_data;
  end

  // Line buffers carry no reset; a window only uses rows written this frame.
  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      lb2[cur_col] <= lb1_rd;
      lb1[cur_col] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
          tap_q[i][j] <= '0;
        end
      end
    end else begin
      out_valid  <= emit;
      frame_done <= emit && at_last_row && at_last_col;
      if (in_valid) begin
        col_q <= nxt_col;
        row_q <= nxt_row;
        win_q <= win_d;
      end
      // Taps capture only complete windows, so idle cycles hold the last one.
      if (emit) begin
        tap_q   <= win_d;
        out_row <= cur_row - RW'(2);
        out_col <= cur_col - CW'(2);
      end
    end
  end

  assign tap_en = (ZERO_IDLE != 0) ? out_valid : 1'b1;

  assign win1 = tap_en ? tap_q[0][0] : '0;
  assign win2 = tap_en ? tap_q[0][1] : '0;
  assign win3 = tap_en ? tap_q[0][2] : '0;
  assign win4 = tap_en ? tap_q[1][0] : '0;
  assign win5 = tap_en ? tap_q[1][1] : '0;
  assign win6 = tap_en ? tap_q[1][2] : '0;
  assign win7 = tap_en ? tap_q[2][0] : '0;
  assign win8 = tap_en ? tap_q[2][1] : '0;
  assign win9 = tap_en ? tap_q[2][2] : '0;

endmodule

// File: doc/window_3x3_stream.md
# window_3x3_stream

Streaming 3x3 neighbourhood generator for the image-filter datapath. It replaces the frame-sized read/write memory with two line buffers, so one full-frame array is no longer needed. The block accepts one pixel per valid cycle in raster order and emits every fully-populated 3x3 window of the frame, with each window's output coordinates. Downstream 3x3 convolution and filter stages consume the nine tap ports directly.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 258, input frame width in pixels (must be >= 3)
- IMG_H, 34, input frame height in pixels (must be >= 3)
- ZERO_IDLE, 1, 1: tap ports read 0 while out_valid=0; 0: taps hold their last value

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  in_data carries a pixel this cycle
- in_sof  in  1  start of frame, qualified by in_valid; forces this pixel to position (0,0)
- in_data  in  DATA_W  input pixel, raster order
- out_valid  out  1  window on the tap ports is valid this cycle
- win1..win9  out  DATA_W each  window taps, row-major: win1 = top-left, win3 = top-right, win9 = bottom-right (newest pixel)
- out_row  out  $clog2(IMG_H)  output row of the window's top-left corner, 0..IMG_H-3
- out_col  out  $clog2(IMG_W)  output column of the window's top-left corner, 0..IMG_W-3
- frame_done  out  1  one-cycle pulse alongside the last window of a frame

## Operation
- The input position counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on cycles where in_valid=1. Gaps of any length are allowed.
- Line buffers:
  - lb1 holds row r-1 and lb2 holds row r-2. Each is IMG_W x DATA_W and is addressed by col.
  - On an accepted pixel at (r,c): read lb1[c] and lb2[c]; write lb2[c] <= lb1[c] and lb1[c] <= in_data.
  - Reads are combinational (same cycle).
- Window register:
  - A 3x3 array shifts one column left per accepted pixel.
  - The new right column is {lb2[c], lb1[c], in_data}, placed in the win3/win6/win9 positions.
- Window emit condition: the accepted pixel has r >= 2 and c >= 2.
  - out_row = r-2 and out_col = c-2.
  - Each frame produces (IMG_W-2)*(IMG_H-2) windows. No padding is applied; the caller supplies a pre-padded frame when it needs a same-size result.
- Position wrap:
  - At c = IMG_W-1, col goes to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both counters go to 0 and frame_done is asserted with that window.
- in_sof:
  - If in_valid=1 and in_sof=1, the pixel is treated as (0,0) whatever the counters hold, and the counters continue from (0,1). Any partial frame is abandoned without a frame_done.
  - in_sof with in_valid=0 is ignored.
- Line buffer contents are never reset. Stale data cannot reach a valid window, because emission requires two full rows to have been written in the current frame.

## Timing
- Latency is 1 cycle: a pixel accepted at edge N produces out_valid, taps, out_row/out_col and frame_done, all registered, valid after edge N.
- out_valid is high for exactly one cycle per emitted window. Back-to-back in_valid gives back-to-back windows with no bubbles inside a row.
- There are no bubbles for row wrap or frame wrap. The next frame's pixel (0,0) may follow the last pixel of a frame on the very next cycle.
- The block applies no backpressure: every in_valid pixel is accepted, and downstream must consume at line rate.
- Reset values, applied on the first rising edge with rst=1:
  - row, col, out_row, out_col, window registers: 0
  - out_valid, frame_done: 0
  - win1..win9: 0
- rst asserted mid-frame discards the frame; the next accepted pixel is (0,0).
- rst together with in_valid: rst wins and the pixel is dropped.
- With ZERO_IDLE=1, the taps are gated by out_valid, so win1..win9 read 0 on every cycle where out_valid=0.

## Test plan
- IMG_W=5, IMG_H=4, pixel value = 10r+c, in_valid continuous:
  - The first out_valid comes one cycle after pixel 22 is accepted, with win1..win9 = 0,1,2,10,11,12,20,21,22 and out_row=0, out_col=0.
  - Exactly 6 windows are produced.
  - The last window has win1=12, win9=34 and out_row=1, out_col=2, with frame_done=1.
- Same frame with in_valid toggling 1,0,1,0: the window values and count are identical to the continuous case, and out_valid never asserts in a cycle that follows an in_valid=0 cycle.
- Two frames back-to-back: second frame pixel value = 100+10r+c. The second frame's first window is 100,101,102,110,...,122 with no contamination from frame 1, and frame_done pulses exactly twice.
- in_sof on the 7th pixel of a frame: no frame_done is produced for the abandoned frame, and the restarted frame yields 6 correct windows starting at out_row=0, out_col=0.
- rst pulsed for one cycle after 12 pixels: the outputs are 0 the following cycle. A fresh 5x4 frame then yields 6 correct windows.
- ZERO_IDLE=0 vs 1 with idle gaps:
  - With ZERO_IDLE=0, the taps hold the last window during gaps.
  - With ZERO_IDLE=1, the taps read 0 whenever out_valid=0.
- Default parameters 258x34: 8192 windows with out_col max 255 and out_row max 31, compared pixel-exact against the software 3x3 extraction.
